// File: rtl/fft_mdc_pkg.sv
// Shared constants and types for the 32-point MDC FFT datapath.
package fft_mdc_pkg;

    localparam int FFT_WIDTH = 9;
    localparam int FFT_N     = 32;

    // Upper-path delay of each radix-2 MDC stage, halving toward the output.
    localparam int S1_DELAY  = 16;
    localparam int S2_DELAY  = 8;
    localparam int S3_DELAY  = 4;
    localparam int S4_DELAY  = 2;
    localparam int S5_DELAY  = 1;

    typedef struct packed {
        logic signed [FFT_WIDTH-1:0] re;
        logic signed [FFT_WIDTH-1:0] im;
    } cplx_t;

endpackage

// File: rtl/mdc_delay_line.sv
// Enable-gated shift register. q is the word written DEPTH enables ago.
module mdc_delay_line #(
    parameter int DEPTH = 1,
    parameter int W     = 18
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_stage
            logic [W-1:0] data_reg;
            if (gi == 0) begin : g_head
                // Head stage captures the incoming word on each enable.
                always_ff @(posedge clk) begin
                    if (rst)
                        data_reg <= '0;
                    else if (en)
                        data_reg <= d;
                end
            end else begin : g_tail
                // Later stages take over their predecessor's word on each enable.
                always_ff @(posedge clk) begin
                    if (rst)
                        data_reg <= '0;
                    else if (en)
                        data_reg <= g_stage[gi-1].data_reg;
                end
            end
        end
    endgenerate

    assign q = g_stage[DEPTH-1].data_reg;

endmodule

// File: rtl/mdc_stage5_delay_ctrl.sv
// Input-side delay/sequencing stage feeding the last MDC commutator.
// Holds the pair index, the priming counter and the output registers.
module mdc_stage5_delay_ctrl
    import fft_mdc_pkg::*;
#(
    parameter int WIDTH = FFT_WIDTH,
    parameter int DEPTH = S5_DELAY
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mode,
    input  logic             in_valid,
    input  logic             in_sof,
    input  logic [WIDTH-1:0] inU_re,
    input  logic [WIDTH-1:0] inU_im,
    input  logic [WIDTH-1:0] inL_re,
    input  logic [WIDTH-1:0] inL_im,
    output logic             out_valid,
    output logic             out_sof,
    output logic [WIDTH-1:0] inUI_re,
    output logic [WIDTH-1:0] inUI_im,
    output logic [WIDTH-1:0] inLI_re,
    output logic [WIDTH-1:0] inLI_im,
    output logic             state5_com_flag,
    output logic             mode_out
);

    localparam int PERIOD = 2 * DEPTH;
    localparam int IDX_W  = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam int CNT_W  = $clog2(DEPTH + 1);

    logic [IDX_W-1:0]   idx_reg;
    logic [IDX_W-1:0]   idx_cur;
    logic [IDX_W-1:0]   idx_next;
    logic [CNT_W-1:0]   primed_cnt_reg;
    logic               primed;
    logic               shift_en;
    logic               pass;
    logic [2*WIDTH-1:0] tail;

    logic               out_valid_reg;
    logic               out_sof_reg;
    logic [WIDTH-1:0]   ui_re_reg;
    logic [WIDTH-1:0]   ui_im_reg;
    logic [WIDTH-1:0]   li_re_reg;
    logic [WIDTH-1:0]   li_im_reg;
    logic               flag_reg;
    logic               mode_out_reg;

    // The delay line only moves on accepted samples in switch mode, so bypass
    // traffic leaves its contents intact for when switching resumes.
    assign shift_en = in_valid & ~mode;

    mdc_delay_line #(
        .DEPTH (DEPTH),
        .W     (2 * WIDTH)
    ) u_delay_line (
        .clk (clk),
        .rst (rst),
        .en  (shift_en),
        .d   ({inU_re, inU_im}),
        .q   (tail)
    );

    // Index of the sample being accepted (frame start forces 0) and its successor.
    always_comb begin
        idx_cur  = in_sof ? '0 : idx_reg;
        idx_next = (idx_cur == IDX_W'(PERIOD - 1)) ? '0 : idx_cur + 1'b1;
        primed   = (primed_cnt_reg == CNT_W'(DEPTH));
        pass     = mode | primed;
    end

    // Pair index and priming count advance only on accepted samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_reg        <= '0;
            primed_cnt_reg <= '0;
        end else if (in_valid) begin
            idx_reg <= idx_next;
            if (mode)
                primed_cnt_reg <= '0;
            else if (!primed)
                primed_cnt_reg <= primed_cnt_reg + 1'b1;
        end
    end

    // Output pair registers; data, flag and mode hold across idle cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_reg <= 1'b0;
            out_sof_reg   <= 1'b0;
            ui_re_reg     <= '0;
            ui_im_reg     <= '0;
            li_re_reg     <= '0;
            li_im_reg     <= '0;
            flag_reg      <= 1'b0;
            mode_out_reg  <= 1'b0;
        end else begin
            out_valid_reg <= in_valid & pass;
            out_sof_reg   <= in_valid & in_sof & pass;
            if (in_valid) begin
                if (mode) begin
                    ui_re_reg <= inU_re;
                    ui_im_reg <= inU_im;
                    flag_reg  <= 1'b1;
                end else begin
                    ui_re_reg <= tail[2*WIDTH-1:WIDTH];
                    ui_im_reg <= tail[WIDTH-1:0];
                    flag_reg  <= (idx_cur < IDX_W'(DEPTH));
                end
                li_re_reg    <= inL_re;
                li_im_reg    <= inL_im;
                mode_out_reg <= mode;
            end
        end
    end

    assign out_valid       = out_valid_reg;
    assign out_sof         = out_sof_reg;
    assign inUI_re         = ui_re_reg;
    assign inUI_im         = ui_im_reg;
    assign inLI_re         = li_re_reg;
    assign inLI_im         = li_im_reg;
    assign state5_com_flag = flag_reg;
    assign mode_out        = mode_out_reg;

endmodule

// File: tb/tb_mdc_stage5_delay_ctrl.sv
// Directed bench for the stage-5 delay/sequence controller (DEPTH=2, WIDTH=9).
// The imaginary part of every driven sample is the bitwise NOT of its real
// part; a real part of 0 marks a reset/empty slot whose imaginary part is 0.
module tb_mdc_stage5_delay_ctrl;

    localparam int WIDTH = 9;
    localparam int DEPTH = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             mode;
    logic             in_valid;
    logic             in_sof;
    logic [WIDTH-1:0] inU_re, inU_im, inL_re, inL_im;
    logic             out_valid, out_sof, state5_com_flag, mode_out;
    logic [WIDTH-1:0] inUI_re, inUI_im, inLI_re, inLI_im;

    int checks = 0;
    int errors = 0;
    int txn    = 0;

    // Expected outputs for the six-sample fill sequence U=1..6, L=10..15.
    int fill_v [6] = '{0, 0, 1, 1, 1, 1};
    int fill_u [6] = '{0, 0, 1, 2, 3, 4};
    int fill_f [6] = '{1, 1, 0, 0, 1, 1};

    mdc_stage5_delay_ctrl #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .mode            (mode),
        .in_valid        (in_valid),
        .in_sof          (in_sof),
        .inU_re          (inU_re),
        .inU_im          (inU_im),
        .inL_re          (inL_re),
        .inL_im          (inL_im),
        .out_valid       (out_valid),
        .out_sof         (out_sof),
        .inUI_re         (inUI_re),
        .inUI_im         (inUI_im),
        .inLI_re         (inLI_re),
        .inLI_im         (inLI_im),
        .state5_com_flag (state5_com_flag),
        .mode_out        (mode_out)
    );

    always #5 clk = ~clk;

    function automatic int im_of(input int x);
        return (x == 0) ? 0 : (-x - 1);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    // Apply one cycle of inputs, then sample just after the active edge.
    task automatic drive(input logic r, input logic v, input logic s, input logic m,
                         input int u, input int l);
        rst      = r;
        in_valid = v;
        in_sof   = s;
        mode     = m;
        inU_re   = u[WIDTH-1:0];
        inU_im   = ~u[WIDTH-1:0];
        inL_re   = l[WIDTH-1:0];
        inL_im   = ~l[WIDTH-1:0];
        @(posedge clk);
        #1;
        txn++;
        $display("txn %0d rst=%0b v=%0b sof=%0b mode=%0b U=%0d L=%0d -> ov=%0b osof=%0b UI=%0d LI=%0d flag=%0b mode_out=%0b",
                 txn, r, v, s, m, u, l, out_valid, out_sof, $signed(inUI_re), $signed(inLI_re),
                 state5_com_flag, mode_out);
    endtask

    task automatic expect_out(input string tag, input int v, input int s, input int u,
                              input int l, input int f, input int m);
        check({tag, ".valid"}, {31'b0, out_valid}, v);
        check({tag, ".sof"},   {31'b0, out_sof}, s);
        check({tag, ".ui_re"}, $signed(inUI_re), u);
        check({tag, ".ui_im"}, $signed(inUI_im), im_of(u));
        check({tag, ".li_re"}, $signed(inLI_re), l);
        check({tag, ".li_im"}, $signed(inLI_im), im_of(l));
        check({tag, ".flag"},  {31'b0, state5_com_flag}, f);
        check({tag, ".mode"},  {31'b0, mode_out}, m);
    endtask

    task automatic fill(input string tag);
        for (int k = 0; k < 6; k++) begin
            drive(1'b0, 1'b1, (k == 0), 1'b0, k + 1, k + 10);
            expect_out($sformatf("%s[%0d]", tag, k), fill_v[k], 0, fill_u[k], k + 10, fill_f[k], 0);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset held with every other input active: everything must stay 0.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 1'b1, 1'b1, 7, 8);
            expect_out($sformatf("reset[%0d]", i), 0, 0, 0, 0, 0, 0);
        end

        // Priming then steady switch-mode stream.
        fill("fill");

        // Stall: outputs hold, no loss or duplicate on resume.
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b0, 99, 98);
            expect_out($sformatf("stall[%0d]", i), 0, 0, 4, 15, 1, 0);
        end
        drive(1'b0, 1'b1, 1'b0, 1'b0, 7, 16);
        expect_out("resume0", 1, 0, 5, 16, 0, 0);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 8, 17);
        expect_out("resume1", 1, 0, 6, 17, 0, 0);

        // Resync: frame start arrives while idx=1.
        drive(1'b0, 1'b1, 1'b0, 1'b0, 9, 18);
        expect_out("pre_sync", 1, 0, 7, 18, 1, 0);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 10, 19);
        expect_out("sync0", 1, 1, 8, 19, 1, 0);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 11, 20);
        expect_out("sync1", 1, 0, 9, 20, 1, 0);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 12, 21);
        expect_out("sync2", 1, 0, 10, 21, 0, 0);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 13, 22);
        expect_out("sync3", 1, 0, 11, 22, 0, 0);

        // Bypass with extreme values, including a frame start.
        drive(1'b0, 1'b1, 1'b0, 1'b1, -256, 255);
        expect_out("bypass0", 1, 0, -256, 255, 1, 1);
        drive(1'b0, 1'b1, 1'b1, 1'b1, -1, -256);
        expect_out("bypass_sof", 1, 1, -1, -256, 1, 1);

        // Back to switch mode: re-prime over 2 acceptances, line untouched by bypass.
        drive(1'b0, 1'b1, 1'b0, 1'b0, 20, 30);
        expect_out("reprime0", 0, 0, 12, 30, 1, 0);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 21, 31);
        expect_out("reprime1", 0, 0, 13, 31, 0, 0);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 22, 32);
        expect_out("reprime2", 1, 0, 20, 32, 0, 0);

        // Advance to idx=3, then reset with a valid sample present.
        drive(1'b0, 1'b1, 1'b0, 1'b0, 23, 33);
        expect_out("pre_rst0", 1, 0, 21, 33, 1, 0);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 24, 34);
        expect_out("pre_rst1", 1, 0, 22, 34, 1, 0);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 25, 35);
        expect_out("pre_rst2", 1, 0, 23, 35, 0, 0);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 26, 36);
        expect_out("mid_rst", 0, 0, 0, 0, 0, 0);

        // Refill from a cleared delay line.
        fill("refill");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
